alu_req_arbiter: RTL and testbench

//  Shares the single combinational ALU between two requesters (0: core issue, 1: debug/test port).
//  - Arbitrates requests round-robin and registers the winner's operands onto the ALU inputs.
//  - Captures the ALU result and returns it to the winner over a valid/ready response channel.
//  - Sits between the issue logic and the ALU. Exactly one operation is in flight at a time.

---
 rtl/alu_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU; one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win over requester 1.
module alu_req_arbiter #(
    parameter int OPW  = 8,
    parameter int RESW = 32,
    parameter int CTLW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [CTLW-1:0] req0_op,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [CTLW-1:0] req1_op,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [RESW-1:0] rsp_result,
    output logic            rsp_err,
    output logic [OPW-1:0]  alu_src1,
    output logic [OPW-1:0]  alu_src2,
    output logic [CTLW-1:0] alu_control,
    output logic [3:0]      alu_shamt,
    input  logic [RESW-1:0] alu_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic            last_grant_r;
    logic            winner_r;
    logic            pick_s;
    logic            grant_s;
    logic            rsp_take_s;
    logic [CTLW-1:0] win_op_s;
    logic [OPW-1:0]  win_a_s;
    logic [OPW-1:0]  win_b_s;

    function automatic logic op_is_valid(input logic [CTLW-1:0] op);
        return (op >= CTLW'(1)) && (op <= CTLW'(7));
    endfunction

    // Winner selection among the currently valid requesters
    always_comb begin
        pick_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            pick_s = 1'b0;
`else
            pick_s = ~last_grant_r;
`endif
        end else if (req1_valid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Grant strobes, winner operand mux and response handshake detect
    always_comb begin
        grant_s    = (state_r == ST_IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = grant_s && !pick_s;
        req1_ready = grant_s && pick_s;
        win_op_s   = pick_s ? req1_op : req0_op;
        win_a_s    = pick_s ? req1_a  : req0_a;
        win_b_s    = pick_s ? req1_b  : req0_b;
        rsp_take_s = winner_r ? rsp1_ready : rsp0_ready;
    end

    // Control FSM with all ALU-side and response-side outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            winner_r     <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_result   <= {RESW{1'b0}};
            rsp_err      <= 1'b0;
            alu_src1     <= {OPW{1'b0}};
            alu_src2     <= {OPW{1'b0}};
            alu_control  <= {CTLW{1'b0}};
            alu_shamt    <= 4'd0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        winner_r     <= pick_s;
                        last_grant_r <= pick_s;
                        busy         <= 1'b1;
                        if (op_is_valid(win_op_s)) begin
                            state_r     <= ST_EXEC;
                            alu_src1    <= win_a_s;
                            alu_src2    <= win_b_s;
                            alu_control <= win_op_s;
                            alu_shamt   <= win_b_s[3:0];
                        end else begin
                            // Unsupported op: answer immediately, ALU never driven
                            state_r    <= ST_RESP;
                            rsp_result <= {RESW{1'b0}};
                            rsp_err    <= 1'b1;
                            rsp0_valid <= ~pick_s;
                            rsp1_valid <= pick_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state_r     <= ST_RESP;
                    rsp_result  <= alu_result;
                    rsp_err     <= 1'b0;
                    rsp0_valid  <= ~winner_r;
                    rsp1_valid  <= winner_r;
                    alu_src1    <= {OPW{1'b0}};
                    alu_src2    <= {OPW{1'b0}};
                    alu_control <= {CTLW{1'b0}};
                    alu_shamt   <= 4'd0;
                end
                ST_RESP: begin
                    if (rsp_take_s) begin
                        state_r    <= ST_IDLE;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rsp_result <= {RESW{1'b0}};
                        rsp_err    <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp0_valid  <= 1'b0;
                    rsp1_valid  <= 1'b0;
                    rsp_result  <= {RESW{1'b0}};
                    rsp_err     <= 1'b0;
                    alu_src1    <= {OPW{1'b0}};
                    alu_src2    <= {OPW{1'b0}};
                    alu_control <= {CTLW{1'b0}};
                    alu_shamt   <= 4'd0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: a behavioural ALU closes the loop, responses are
// checked in grant order against expectations queued at stimulus time.
module tb_alu_req_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [5:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [7:0]  alu_src1, alu_src2;
    logic [5:0]  alu_control;
    logic [3:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        busy;

    int  errors = 0;
    int  checks = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    alu_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
        .alu_shamt(alu_shamt), .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [31:0] alu_model(input logic [5:0] ctl, input logic [7:0] a,
                                              input logic [7:0] b, input logic [3:0] sh);
        logic [31:0] x, y;
        x = {24'd0, a};
        y = {24'd0, b};
        case (ctl)
            6'd1:    return x + y;
            6'd2:    return x - y;
            6'd3:    return x << sh;
            6'd4:    return {31'd0, x < y};
            6'd5:    return x | y;
            6'd6:    return x ^ y;
            6'd7:    return {31'd0, x > y};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        return (op >= 6'd1) && (op <= 6'd7);
    endfunction

    assign alu_result = alu_model(alu_control, alu_src1, alu_src2, alu_shamt);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: handshakes are taken at the rising edge
    always @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? (rsp0_valid && rsp0_ready) : (rsp1_valid && rsp1_ready)) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        sb_t e;
                        e = sb.pop_front();
                        check("rsp_port", p, e.id);
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_err", rsp_err, e.err);
                    end
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [5:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic push_exp(input logic id, input logic [5:0] op, input logic [7:0] a,
                            input logic [7:0] b);
        sb_t e;
        e.id  = id;
        e.res = alu_model(op, a, b, b[3:0]);
        e.err = !op_ok(op);
        sb.push_back(e);
    endtask

    task automatic wait_ready(input logic id);
        int n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("grant_in_time", n < 40, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk); n++;
        end
        check("idle_in_time", n < 40, 1);
    endtask

    // Drives one request, returns at the negedge of the cycle after acceptance
    task automatic issue(input logic id, input logic [5:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        push_exp(id, op, a, b);
        set_req(id, 1'b1, op, a, b);
        wait_ready(id);
        @(negedge clk);
        set_req(id, 1'b0, 6'd0, 8'd0, 8'd0);
    endtask

    task automatic both(input logic [5:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [5:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic first);
        if (first) begin
            push_exp(1'b1, op1, a1, b1); push_exp(1'b0, op0, a0, b0);
        end else begin
            push_exp(1'b0, op0, a0, b0); push_exp(1'b1, op1, a1, b1);
        end
        set_req(1'b0, 1'b1, op0, a0, b0);
        set_req(1'b1, 1'b1, op1, a1, b1);
        #1;
        check("both_rdy0", req0_ready, !first);
        check("both_rdy1", req1_ready, first);
        @(negedge clk);
        set_req(first, 1'b0, 6'd0, 8'd0, 8'd0);
        wait_ready(!first);
        @(negedge clk);
        set_req(!first, 1'b0, 6'd0, 8'd0, 8'd0);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 6'd1, 8'd1, 8'd1);
        set_req(1'b1, 1'b0, 6'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_alu", {alu_src1, alu_src2, alu_control, alu_shamt}, 0);
        check("rst_rsp", {rsp_result, rsp_err}, 0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'd0, 8'd0, 8'd0);
        rst = 1'b0;

        // Basic add with exact latency
        issue(1'b0, 6'd1, 8'd5, 8'd3);
        check("t1_alu_control", alu_control, 1);
        check("t1_alu_src1", alu_src1, 5);
        check("t1_rsp0_early", rsp0_valid, 0);
        @(negedge clk);
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_result", rsp_result, 8);
        check("t1_alu_cleared", alu_control, 0);
        wait_idle();

        // Fresh reset so last_grant is back at 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        both(6'd2, 8'd10, 8'd4, 6'd5, 8'hF0, 8'h0F, 1'b0);
        issue(1'b0, 6'd1, 8'd1, 8'd2);
        wait_idle();
`ifdef ALU_ARB_FIXED_PRIO_EN
        both(6'd1, 8'd1, 8'd1, 6'd2, 8'd3, 8'd5, 1'b0);
`else
        both(6'd1, 8'd1, 8'd1, 6'd2, 8'd3, 8'd5, 1'b1);
`endif

        // Unsupported op: error response one cycle after accept
        issue(1'b1, 6'd9, 8'd1, 8'd1);
        check("t3_rsp1_valid", rsp1_valid, 1);
        check("t3_err", rsp_err, 1);
        check("t3_result", rsp_result, 0);
        check("t3_alu_control", alu_control, 0);
        wait_idle();

        // Response back-pressure with a competing request held
        rsp0_ready = 1'b0;
        issue(1'b0, 6'd4, 8'd2, 8'd7);
        @(negedge clk);
        push_exp(1'b1, 6'd7, 8'd9, 8'd3);
        set_req(1'b1, 1'b1, 6'd7, 8'd9, 8'd3);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_hold_valid", rsp0_valid, 1);
            check("t4_hold_result", rsp_result, 1);
            check("t4_hold_busy", busy, 1);
            check("t4_no_grant", req1_ready, 0);
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t4_released", rsp0_valid, 0);
        check("t4_next_grant", req1_ready, 1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 6'd0, 8'd0, 8'd0);
        wait_idle();

        // Shift: shamt follows operand b
        issue(1'b0, 6'd3, 8'd1, 8'd4);
        check("t6_shamt", alu_shamt, 4);
        check("t6_control", alu_control, 3);
        wait_idle();

        // Reset while in EXEC discards the op
        set_req(1'b0, 1'b1, 6'd1, 8'd4, 8'd4);
        wait_ready(1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'd0, 8'd0, 8'd0);
        check("t5_exec_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_alu", {alu_src1, alu_src2, alu_control, alu_shamt}, 0);
        check("t5_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        rst = 1'b0;
        push_exp(1'b0, 6'd1, 8'd7, 8'd1);
        set_req(1'b0, 1'b1, 6'd1, 8'd7, 8'd1);
        #1;
        check("t5_first_accept", req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'd0, 8'd0, 8'd0);
        wait_idle();

        // Random single requests, including unsupported codes
        for (int k = 0; k < 16; k++) begin
            logic       id;
            logic [5:0] op;
            logic [7:0] a, b;
            id = 1'($urandom_range(0, 1));
            op = 6'($urandom_range(0, 10));
            a  = 8'($urandom);
            b  = 8'($urandom);
            issue(id, op, a, b);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
